// File: rtl/exe_mem_pipe.sv
// exe_mem_pipe: EXE->MEM pipeline register built as a two-entry skid buffer.
//
// Purpose: carries one execute-stage result (pc, instruction, destination
// index, memory/write-back control bits, store data, ALU result) into the
// memory stage.
// in_ready is a flop, so there is no combinational path from out_ready back
// upstream. Throughput is one payload per cycle and latency is one cycle.
//
// Ports:
//   clk, rst (sync, active-low), flush
//   in_valid / in_ready   : upstream handshake
//   out_valid / out_ready : downstream handshake
//   in_* / out_*          : payload fields (pc, instr, dst, mem_read,
//                           mem_write, wb_en, val_rm, alu_res)
//   fwd_valid, fwd_dst, fwd_data : forwarding taps, present only when the
//                           macro EXE_MEM_PIPE_FWD_EN is defined
//   dbg_state             : 2'b00 EMPTY, 2'b01 ONE, 2'b11 FULL
//
// Handshake: a payload moves on a cycle where valid and ready are both high
// at the rising edge. The sender holds valid and payload stable until that
// happens. The receiver's ready depends only on its own registered state.
module exe_mem_pipe #(
  parameter int WORD_WIDTH = 32,
  parameter int DST_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [WORD_WIDTH-1:0] in_pc,
  input  logic [WORD_WIDTH-1:0] in_instr,
  input  logic [DST_WIDTH-1:0]  in_dst,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_wb_en,
  input  logic [WORD_WIDTH-1:0] in_val_rm,
  input  logic [WORD_WIDTH-1:0] in_alu_res,
  output logic [WORD_WIDTH-1:0] out_pc,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [DST_WIDTH-1:0]  out_dst,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_wb_en,
  output logic [WORD_WIDTH-1:0] out_val_rm,
  output logic [WORD_WIDTH-1:0] out_alu_res,
`ifdef EXE_MEM_PIPE_FWD_EN
  output logic                  fwd_valid,
  output logic [DST_WIDTH-1:0]  fwd_dst,
  output logic [WORD_WIDTH-1:0] fwd_data,
`endif
  output logic [1:0]            dbg_state
);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instr;
    logic [DST_WIDTH-1:0]  dst;
    logic                  mem_read;
    logic                  mem_write;
    logic                  wb_en;
    logic [WORD_WIDTH-1:0] val_rm;
    logic [WORD_WIDTH-1:0] alu_res;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  payload_t main_q, main_d, skid_q, skid_d, in_pl;
  logic     main_valid_q, main_valid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     accept, pop;
  state_t   state;

  assign in_pl = '{pc: in_pc, instr: in_instr, dst: in_dst,
                   mem_read: in_mem_read, mem_write: in_mem_write,
                   wb_en: in_wb_en, val_rm: in_val_rm, alu_res: in_alu_res};

  // State register. Reset clears every payload bit so the outputs read 0.
  // in_ready stays low while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Next-state logic. The valid bits define the state:
  // EMPTY = neither valid, ONE = main valid, FULL = both valid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    accept       = in_valid && in_ready_q;
    pop          = main_valid_q && out_ready;

    if (flush) begin
      // Payload registers keep their contents so the data outputs hold.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = in_pl;
        main_valid_d = 1'b1;
      end
    end else if (!skid_valid_q) begin
      if (accept && pop) begin
        main_d = in_pl;
      end else if (accept) begin
        skid_d       = in_pl;
        skid_valid_d = 1'b1;
      end else if (pop) begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (pop) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end
    end

    // Ready next cycle exactly when the skid slot will be free.
    in_ready_d = !skid_valid_d;
  end

  // Output logic.
  always_comb begin
    if (skid_valid_q)      state = ST_FULL;
    else if (main_valid_q) state = ST_ONE;
    else                   state = ST_EMPTY;

    dbg_state     = state;
    in_ready      = in_ready_q;
    out_valid     = main_valid_q;
    out_pc        = main_q.pc;
    out_instr     = main_q.instr;
    out_dst       = main_q.dst;
    out_val_rm    = main_q.val_rm;
    out_alu_res   = main_q.alu_res;
    // A bubble must never start a memory access or a write-back.
    out_mem_read  = main_q.mem_read  && main_valid_q;
    out_mem_write = main_q.mem_write && main_valid_q;
    out_wb_en     = main_q.wb_en     && main_valid_q;
`ifdef EXE_MEM_PIPE_FWD_EN
    // Loads are excluded because their data only exists after memory.
    fwd_valid     = main_valid_q && main_q.wb_en && !main_q.mem_read;
    fwd_dst       = main_q.dst;
    fwd_data      = main_q.alu_res;
`endif
  end

endmodule

// File: tb/tb_exe_mem_pipe.sv
// Bench for exe_mem_pipe: randomized and directed stimulus, a queue-based
// reference model, and an output monitor that scores every presented payload.
module tb_exe_mem_pipe;

  localparam int WW = 32;
  localparam int DW = 4;

  typedef struct packed {
    logic [WW-1:0] pc;
    logic [WW-1:0] instr;
    logic [DW-1:0] dst;
    logic          mr;
    logic          mw;
    logic          wb;
    logic [WW-1:0] val;
    logic [WW-1:0] alu;
  } pl_t;

  localparam int PW = $bits(pl_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  pl_t           cur_pl;
  logic [WW-1:0] out_pc, out_instr, out_val_rm, out_alu_res;
  logic [DW-1:0] out_dst;
  logic          out_mem_read, out_mem_write, out_wb_en;
  logic [1:0]    dbg_state;
`ifdef EXE_MEM_PIPE_FWD_EN
  logic          fwd_valid;
  logic [DW-1:0] fwd_dst;
  logic [WW-1:0] fwd_data;
`endif

  exe_mem_pipe #(.WORD_WIDTH(WW), .DST_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .in_pc(cur_pl.pc), .in_instr(cur_pl.instr), .in_dst(cur_pl.dst),
    .in_mem_read(cur_pl.mr), .in_mem_write(cur_pl.mw), .in_wb_en(cur_pl.wb),
    .in_val_rm(cur_pl.val), .in_alu_res(cur_pl.alu),
    .out_pc(out_pc), .out_instr(out_instr), .out_dst(out_dst),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_wb_en(out_wb_en), .out_val_rm(out_val_rm), .out_alu_res(out_alu_res),
`ifdef EXE_MEM_PIPE_FWD_EN
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [PW-1:0] exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;      // payloads the pipe should be holding
  logic model_ready = 1'b0; // in_ready expected in the current cycle
  logic model_init = 1'b0;
  pl_t  last_pl = '0;       // value the data outputs should hold when idle
  logic seen_c = 1'b0;

  task automatic chk(input string name, input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic pl_t data_only(input pl_t p);
    pl_t r;
    r    = p;
    r.mr = 1'b0;
    r.mw = 1'b0;
    r.wb = 1'b0;
    return r;
  endfunction

  // Reference model: a FIFO of at most two payloads. Ready means fewer than
  // two payloads are held. Flush and reset empty it, and reset also blocks
  // ready for that cycle. Delivered payloads leave the queue in the monitor.
  always @(posedge clk) begin
    logic acc, pp;
    acc = in_valid && model_ready;
    pp  = (model_cnt > 0) && out_ready;
    if (!rst) begin
      exp_q.delete();
      model_cnt   = 0;
      model_ready = 1'b0;
      last_pl     = '0;
      model_init  = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      model_cnt   = 0;
      model_ready = 1'b1;
    end else begin
      if (pp) model_cnt--;
      if (acc) begin
        model_cnt++;
        exp_q.push_back(cur_pl);
      end
      model_ready = (model_cnt < 2);
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    pl_t d, ref_p;
    if (model_init) begin
      d = {out_pc, out_instr, out_dst, out_mem_read, out_mem_write, out_wb_en,
           out_val_rm, out_alu_res};
      chk("in_ready", PW'(in_ready), PW'(model_ready));
      chk("out_valid", PW'(out_valid), PW'(model_cnt > 0));
      ref_p = last_pl;
      if (out_valid) begin
        if (out_alu_res == 32'hC) seen_c = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", d, '0);
        end else begin
          ref_p = exp_q[0];
          chk("payload", d, exp_q[0]);
          last_pl = exp_q[0];
          if (out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_data_hold", data_only(d), data_only(last_pl));
        chk("idle_ctl_gated", PW'({out_mem_read, out_mem_write, out_wb_en}), '0);
      end
`ifdef EXE_MEM_PIPE_FWD_EN
      chk("fwd_valid", PW'(fwd_valid),
          PW'((model_cnt > 0) && ref_p.wb && !ref_p.mr));
      chk("fwd_dst", PW'(fwd_dst), PW'(ref_p.dst));
      chk("fwd_data", PW'(fwd_data), PW'(ref_p.alu));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Applies the inputs for one cycle.
  task automatic cyc(input logic v, input pl_t p, input logic ordy,
                     input logic fl, input logic r);
    in_valid  = v;
    cur_pl    = p;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  function automatic pl_t mk(input logic [WW-1:0] alu, input logic [DW-1:0] dst,
                             input logic mr, input logic mw, input logic wb);
    pl_t p;
    p.pc    = $urandom;
    p.instr = $urandom;
    p.val   = $urandom;
    p.alu   = alu;
    p.dst   = dst;
    p.mr    = mr;
    p.mw    = mw;
    p.wb    = wb;
    return p;
  endfunction

  function automatic pl_t rand_pl();
    return mk($urandom, DW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endfunction

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, rand_pl(), ordy, 1'b0, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cur_pl = '0;
    @(posedge clk); #1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1);

    // streaming: four back-to-back accepts with the output always ready
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, mk(WW'(i * 16), DW'(i), 1'b0, 1'b0, 1'b1), 1'b1, 1'b0, 1'b1);
    idle(1'b1, 2);

    // stall: fill to FULL, hold, then drain
    cyc(1'b1, mk(32'hA, 4'd1, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(32'hB, 4'd2, 1'b0, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1);
    idle(1'b0, 2);
    idle(1'b1, 3);

    // flush while FULL, with a new payload offered in the flush cycle
    cyc(1'b1, mk(32'h1, 4'd3, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(32'h2, 4'd4, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(32'hC, 4'd6, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1, 1'b1);
    idle(1'b1, 3);
    checks++;
    if (seen_c) begin
      errors++;
      $display("FAIL flushed_0xC_seen got=1 exp=0");
    end

    // bubble gating: held store with write-back, popped with nothing behind it
    cyc(1'b1, mk(32'h55, 4'd7, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // reset asserted while FULL
    cyc(1'b1, mk(32'h3, 4'd8, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, mk(32'h4, 4'd9, 1'b0, 1'b1, 1'b1), 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2);

    // forwarding taps: ALU result then a load to the same register
    cyc(1'b1, mk(32'h77, 4'd5, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1);
    cyc(1'b1, mk(32'h77, 4'd5, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b1);
    idle(1'b1, 2);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), rand_pl(),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0),
          1'($urandom_range(0, 99) != 0));
    idle(1'b1, 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_empty got=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_mem_pipe.md
EXE_MEM_PIPE -- requirements
Module: exe_mem_pipe

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32, giving the width of pc, instruction, val_rm and alu_res.
REQ-002 The block SHALL have parameter DST_WIDTH, default 4, giving the width of the destination-register index.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it SHALL be synchronous and active-low.
REQ-005 The block SHALL have port flush, input, 1, which discards all held entries.
REQ-006 The block SHALL have port in_valid, input, 1, meaning the upstream payload is valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block can accept a payload this cycle.
REQ-008 The block SHALL have port out_valid, output, 1, meaning the downstream payload is valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning downstream accepts the payload this cycle.
REQ-010 The block SHALL have ports in_pc and out_pc, input and output, WORD_WIDTH, carrying the program counter.
REQ-011 The block SHALL have ports in_instr and out_instr, input and output, WORD_WIDTH, carrying the instruction word.
REQ-012 The block SHALL have ports in_dst and out_dst, input and output, DST_WIDTH, carrying the destination register index.
REQ-013 The block SHALL have ports in_mem_read and out_mem_read, input and output, 1, carrying the load control bit.
REQ-014 The block SHALL have ports in_mem_write and out_mem_write, input and output, 1, carrying the store control bit.
REQ-015 The block SHALL have ports in_wb_en and out_wb_en, input and output, 1, carrying the write-back enable.
REQ-016 The block SHALL have ports in_val_rm and out_val_rm, input and output, WORD_WIDTH, carrying the store data operand.
REQ-017 The block SHALL have ports in_alu_res and out_alu_res, input and output, WORD_WIDTH, carrying the ALU result or address.

Function
REQ-018 The block SHALL hold a main (output) register and a skid register, each with its own valid bit.
- States: EMPTY = neither valid; ONE = main valid; FULL = both valid.
REQ-019 An accept SHALL occur when in_valid && in_ready, and a pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal the registered value of NOT skid_valid; it SHALL be a registered signal with no combinational path from out_ready.
REQ-021 out_valid SHALL equal main_valid, and out_pc through out_alu_res SHALL be driven directly from the main register.
REQ-022 State transitions SHALL be as follows:
- EMPTY + accept -> ONE, main loaded with the input payload.
- ONE + accept + pop -> ONE, main loaded with the input payload.
- ONE + accept, no pop -> FULL, skid loaded with the input payload.
- ONE + pop, no accept -> EMPTY.
- FULL + pop -> ONE, main loaded with the skid payload.
- FULL, no pop -> FULL.
- Any other combination -> hold.
REQ-023 Latency SHALL be 1 cycle from accept to out_valid, and sustained throughput SHALL be 1 payload per cycle when out_ready is held high.
REQ-024 out_mem_read, out_mem_write and out_wb_en SHALL be the stored bits ANDed with out_valid, so that a bubble never issues a memory access or write-back.
REQ-025 When out_valid is 0, the data outputs SHALL hold their last values.
REQ-026 Payload order SHALL be preserved, with no loss or duplication under any out_ready pattern.
REQ-027 flush SHALL take priority over accept and pop: the next state SHALL be EMPTY, both valid bits SHALL clear, the input presented in the flush cycle SHALL be discarded, and in_ready SHALL be 1 on the next cycle.
REQ-028 A payload that is popped in the same cycle as a flush SHALL count as delivered to downstream.

Reset
REQ-029 While rst is 0 at a clock edge, the block SHALL enter EMPTY with all payload registers at 0, out_valid 0, all gated control outputs 0, and in_ready 0.
REQ-030 On the first edge with rst equal to 1, in_ready SHALL become 1; a reset asserted in any state, including FULL, SHALL discard all held entries.

Configuration
REQ-031 When macro EXE_MEM_PIPE_FWD_EN is defined, the block SHALL add the following forwarding outputs:
- fwd_valid, output, 1, = main_valid && main_wb_en && NOT main_mem_read.
- fwd_dst, output, DST_WIDTH, = main dst.
- fwd_data, output, WORD_WIDTH, = main alu_res.
REQ-032 When EXE_MEM_PIPE_FWD_EN is undefined, these forwarding ports SHALL NOT exist and the block behaviour SHALL be otherwise identical.

Verification
REQ-033 The bench SHALL cover streaming: out_ready=1, 4 back-to-back accepts with alu_res 0x10, 0x20, 0x30, 0x40 -> out_valid from cycle 1, outputs 0x10..0x40 in consecutive cycles, in_ready constantly 1.
REQ-034 The bench SHALL cover stall: out_ready=0, accept 0xA then 0xB -> state FULL, in_ready=0 on the next cycle, out_alu_res=0xA held; then out_ready=1 -> 0xA popped, then 0xB popped, in_ready returns to 1.
REQ-035 The bench SHALL cover flush in FULL: flush=1 with in_valid=1 carrying 0xC -> next cycle out_valid=0, in_ready=1, and 0xC never appears at the output.
REQ-036 The bench SHALL cover bubble gating: a held payload with wb_en=1 and mem_write=1, then popped with no new accept -> out_wb_en=0 and out_mem_write=0 while out_alu_res holds the old value.
REQ-037 The bench SHALL cover reset mid-operation: rst=0 asserted in state FULL -> next cycle out_valid=0, in_ready=0, and all outputs 0; after rst returns to 1, in_ready=1 after one edge.
REQ-038 The bench SHALL cover forwarding with FWD_EN defined: a held payload with dst=5, wb_en=1, mem_read=0 and alu_res=0x77 -> fwd_valid=1, fwd_dst=5, fwd_data=0x77; with mem_read=1 -> fwd_valid=0.
